sram_ctrl: RTL and testbench

//  Initiator-side controller for the single-port sram block (ADDR/DATA/DEPTH matched).

---
 rtl/sram_ctrl_pkg.sv | 13 +
 rtl/sram_ctrl.sv | 107 ++++++++++
 tb/tb_sram_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the sram initiator controller.
// Only the controller FSM state encoding lives here.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RSP,
    CLEAR
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Initiator-side controller for one single-port sram: request/response
// handshakes, 1-cycle read latency absorption and a bulk-clear sequencer.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  idle;

  assign idle        = (state_q == IDLE);
  assign o_req_ready = idle && !i_clear && !i_rst;
  assign o_busy      = !idle && !i_rst;

  assign o_mem_addr  = addr_q;
  assign o_mem_write = write_q;
  assign o_mem_data  = wdata_q;
  assign o_rsp_valid = rvalid_q;
  assign o_rsp_data  = rdata_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Clear wins over a same-cycle request, which stays pending.
          if (i_clear) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= CLEAR_VALUE;
            write_q <= 1'b1;
            state_q <= CLEAR;
          end else if (i_req_valid) begin
            addr_q  <= i_req_addr;
            wdata_q <= i_req_data;
            write_q <= i_req_write;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          write_q <= 1'b0;
          state_q <= write_q ? IDLE : WAIT;
        end
        WAIT: begin
          rdata_q  <= i_mem_data;
          rvalid_q <= 1'b1;
          state_q  <= RSP;
        end
        RSP: begin
          if (i_rsp_ready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural registered-read sram
// attached to its memory port.
module tb_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [5:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_data;
  logic       clear;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_write;
  logic [5:0] mem_data;
  logic [5:0] mem_rd;

  int ncmp = 0;
  int nfail = 0;

  logic [5:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data;
    mem_rd <= mem[mem_addr];
  end

  sram_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data (rsp_data),
    .i_clear    (clear),
    .o_busy     (busy),
    .o_mem_addr (mem_addr),
    .o_mem_write(mem_write),
    .o_mem_data (mem_data),
    .i_mem_data (mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [5:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_data  = d;
    chk("wr_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_addr", mem_addr, a);
    tick();
    chk("wr_done_write0", mem_write, 0);
    chk("wr_done_ready", req_ready, 1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [5:0] exp,
                         input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    chk({tag, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_v_t0"}, rsp_valid, 0);
    tick();
    chk({tag, "_v_t1"}, rsp_valid, 0);
    tick();
    chk({tag, "_v_t2"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_v_drop"}, rsp_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    clear     = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_ready", req_ready, 1);

    // 1: mid-cycle reset after some activity
    do_write(8'h10, 6'h2A);
    chk("pre_rst_addr", mem_addr, 8'h10);
    chk("pre_rst_data", mem_data, 6'h2A);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", mem_data, 0);
    chk("mid_rst_write", mem_write, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rdata", rsp_data, 0);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_ready", req_ready, 1);

    // 2: write then read
    do_write(8'h10, 6'h2A);
    do_read(8'h10, 6'h2A, "rd10");

    // 3: stalled response
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("stall_v0", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 6'h2A);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stall_rel_ready", req_ready, 1);
    chk("stall_rel_valid", rsp_valid, 0);
    chk("stall_keep_data", rsp_data, 6'h2A);

    // 4: bulk clear
    do_write(8'd0, 6'h3F);
    do_write(8'd128, 6'h3F);
    do_write(8'd255, 6'h3F);
    clear = 1'b1;
    #1;
    chk("clr_blocks_ready", req_ready, 0);
    tick();
    clear = 1'b0;
    n = 1;
    chk("clr_busy", busy, 1);
    chk("clr_first_write", mem_write, 1);
    chk("clr_first_addr", mem_addr, 0);
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("clr_cycles", n, 257);
    chk("clr_end_write", mem_write, 0);
    chk("clr_end_addr", mem_addr, 0);
    do_read(8'd0, 6'h00, "clr_rd0");
    do_read(8'd128, 6'h00, "clr_rd128");
    do_read(8'd255, 6'h00, "clr_rd255");

    // 5: clear beats a same-cycle request
    clear     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'd7;
    req_data  = 6'h15;
    tick();
    clear = 1'b0;
    chk("prio_busy", busy, 1);
    chk("prio_addr", mem_addr, 0);
    n = 0;
    while (!req_ready && n < 400) begin
      tick();
      n++;
    end
    chk("prio_wait", n, 256);
    tick();
    req_valid = 1'b0;
    chk("prio_acc_addr", mem_addr, 8'd7);
    chk("prio_acc_write", mem_write, 1);
    tick();
    req_valid = 1'b1;
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rsp_clr_v", rsp_valid, 1);
    chk("rsp_clr_data", rsp_data, 6'h15);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("rsp_clr_hold", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_clr_idle", busy, 0);
    chk("rsp_clr_ready", req_ready, 1);

    // 6: reset mid-clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (mem_addr != 8'd100 && n < 400) begin
      tick();
      n++;
    end
    chk("abort_reach100", mem_addr, 8'd100);
    #3 rst = 1'b1;
    #1;
    chk("abort_write", mem_write, 0);
    chk("abort_busy", busy, 0);
    #2 rst = 1'b0;
    tick();
    chk("abort_ready", req_ready, 1);
    chk("abort_idle_write", mem_write, 0);
    do_write(8'd200, 6'h11);
    do_read(8'd200, 6'h11, "abort_rd200");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
